// File: rtl/xor_accum.sv
// Pairwise XOR / frame-accumulating XOR unit with a registered result, parity and
// a saturating per-frame beat count with a sticky overflow flag.
module xor_accum #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             last,
    input  logic             clear,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             parity,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             overflow
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             out_valid_q, out_valid_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] ab;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_inc;

    assign ab      = a ^ b;
    assign cnt_sat = (cnt_q == CntMax);
    assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        beat_cnt_d  = beat_cnt_q;
        overflow_d  = overflow_q;

        // Abort discards the frame but leaves the last reported result visible.
        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                StIdle: begin
                    if (!mode || last) begin
                        c_d         = ab;
                        beat_cnt_d  = CntOne;
                        overflow_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d   = ab;
                        cnt_d   = CntOne;
                        ovf_d   = 1'b0;
                        state_d = StAccum;
                    end
                end
                StAccum: begin
                    // mode is only meaningful at frame start.
                    if (last) begin
                        c_d         = acc_q ^ ab;
                        beat_cnt_d  = cnt_inc;
                        overflow_d  = ovf_q | cnt_sat;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = StIdle;
                    end else begin
                        acc_d = acc_q ^ ab;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | cnt_sat;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        parity_d = ^c_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            parity_q    <= 1'b0;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            parity_q    <= parity_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign parity    = parity_q;
    assign beat_cnt  = beat_cnt_q;
    assign overflow  = overflow_q;

endmodule
